// File: rtl/uart_packet_assembler.sv
// UART byte-stream framer: SOF + PACK_NUM payload bytes + XOR checksum,
// with inter-byte timeout, delivered downstream over a valid/ready handshake.
module uart_packet_assembler #(
   parameter int unsigned PACK_NUM    = 9,
   parameter logic [7:0]  SOF_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 104_200,
   parameter int unsigned TO_BIT      = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            i_data,
   input  logic                  i_rx_done_tick,
   input  logic                  i_ready,
   output logic [8*PACK_NUM-1:0] o_packet,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_err_tick,
   output logic [1:0]            o_err_code
);

   localparam int unsigned IDX_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PACK_NUM - 1);
   localparam logic [TO_BIT-1:0] TO_LAST  = TO_BIT'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } state_t;

   state_t                state;
   logic [IDX_W-1:0]      idx;
   logic [7:0]            acc;
   logic [TO_BIT-1:0]     cnt;
   logic [8*PACK_NUM-1:0] shadow;

   assign o_busy = (state != IDLE);

   // Frame FSM, shadow assembly, timeout, commit and handshake in one register block
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         acc        <= '0;
         cnt        <= '0;
         shadow     <= '0;
         o_packet   <= '0;
         o_valid    <= 1'b0;
         o_err_tick <= 1'b0;
         o_err_code <= 2'd0;
      end else begin
         o_err_tick <= 1'b0;
         // A completed transfer drops valid; a commit below on the same edge overrides it
         if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (i_rx_done_tick && (i_data == SOF_BYTE)) begin
                  idx   <= '0;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (i_rx_done_tick) begin
                  shadow[idx*8 +: 8] <= i_data;
                  acc                <= acc ^ i_data;
                  cnt                <= '0;
                  if (idx == LAST_IDX) begin
                     state <= CHECK;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else if (cnt == TO_LAST) begin
                  cnt        <= '0;
                  o_err_tick <= 1'b1;
                  o_err_code <= 2'd2;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CHECK: begin
               if (i_rx_done_tick) begin
                  state <= IDLE;
                  if (i_data == acc) begin
                     if (!o_valid || i_ready) begin
                        o_packet <= shadow;
                        o_valid  <= 1'b1;
                     end else begin
                        o_err_tick <= 1'b1;
                        o_err_code <= 2'd3;
                     end
                  end else begin
                     o_err_tick <= 1'b1;
                     o_err_code <= 2'd1;
                  end
               end else if (cnt == TO_LAST) begin
                  cnt        <= '0;
                  o_err_tick <= 1'b1;
                  o_err_code <= 2'd2;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
